reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Shares the load/in port of one `register` instance between NUM_REQ requesters using a round-robin ready/valid handshake.
- Drives the register's `load` and `in` from registered outputs, so the arbitration logic adds no combinational path into the register.
- Sits between datapath producers (e.g. ALU writeback, memory load, PC-link) and a shared architectural register.

Parameters:
- WIDTH, 4, data width; must match the attached register.
- NUM_REQ, 4, number of requesters (≥2).
- PTR_W, $clog2(NUM_REQ), width of the round-robin pointer (derived; do not override).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester valid.
- wdata  in  NUM_REQ*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH].
- stall  in  1  while high, no grant is issued.
- gnt  out  NUM_REQ  combinational one-hot ready; all zero when no winner.
- reg_load  out  1  registered; connect to register.load.
- reg_in  out  WIDTH  registered; connect to register.in.
- last_id  out  PTR_W  registered index of the most recent winner.

Behaviour:
- Reset (reset=0, async):
  - reg_load=0, reg_in=0, last_id=0.
  - Pointer=0, so requester 0 has highest priority.
  - gnt is forced to 0 while reset is low.
- Arbitration (combinational):
  - Scan from pointer upward, modulo NUM_REQ.
  - The first i with req[i]=1 gets gnt[i]=1, provided stall=0.
  - At most one gnt bit is high.
  - gnt does not depend on wdata.
- Transfer:
  - Occurs at a rising edge where req[i]&gnt[i]=1.
  - Requester i holds wdata stable while req is high.
  - Requester i may keep req high after a transfer to issue a new write.
- Pointer update on transfer: pointer ← (i+1) mod NUM_REQ, with wrap from NUM_REQ-1 to 0. No transfer means the pointer holds.
- Output pipeline:
  - At the transfer edge: reg_load←1, reg_in←wdata[i], last_id←i.
  - At an edge with no transfer: reg_load←0; reg_in and last_id hold.
  - The register captures at the next edge.
  - Latency is 2 edges from handshake to register.out.
- Fairness: with all req held high, grants rotate 0,1,2,3,0,… (one per cycle, full throughput). A continuously requesting requester waits at most NUM_REQ-1 transfers.
- Single requester: it is granted every cycle req is high (back-to-back writes).
- stall:
  - Masks grants combinationally. Pointer and pending reqs are unaffected.
  - reg_load drops at the next edge.
  - stall asserted in the cycle after a transfer does not cancel the already-registered reg_load.
- Reset mid-operation: any pending reg_load is cleared immediately and no write reaches the register. Requesters see gnt=0 and must re-present.

Optional Feature:
- Macro: REG_WRITE_ARB_LOCK_EN.
- When defined:
  - Adds input lock[NUM_REQ-1:0].
  - A transfer with lock[i]=1 leaves the pointer at i, so i keeps top priority.
  - The pointer advances normally on i's first transfer with lock[i]=0, or when req[i]=0 for a cycle while another requester transfers.
  - stall still overrides lock.
- When undefined: no lock port; pure round-robin.

Decomposition:
- Package mips_pkg (shared):
  - ARB_NUM_REQ_DEFAULT=4.
  - Typedef for the requester index.
  - Function onehot_to_idx, reused by this block and the bench.
- One sub-module, rr_pick:
  - Purely combinational.
  - Inputs: req, pointer, enable. Outputs: one-hot gnt, winner index, valid.
  - Implemented as a double-width masked priority encoder.
- The arbiter top holds the pointer register, the output registers and the optional lock logic.

Test Plan:
1. Reset mid-stream: reset=0 for 6 units, release, req=0 → gnt=0, reg_load=0, reg_in=0. Then pull reset low while reg_load=1 → reg_load=0 immediately; register.out stays at its prior value.
2. Single write: req=0100, wdata[2]=4'hA → gnt=0100 in the same cycle; reg_load=1, reg_in=A, last_id=2 after the edge; register.out=A one edge later.
3. Round-robin: req=1111 held, wdata[i]=i+1 → winners 0,1,2,3,0 on consecutive edges; register.out sequence 1,2,3,4,1.
4. Wrap and skip: pointer=3, req=0011 → winner 0, then 1, then 0; requester 3 is absent and is skipped with no bubble.
5. Stall: req=1111, stall=1 for 3 cycles → gnt=0000, reg_load=0 after one edge, last_id unchanged. Release stall → the next winner follows the pre-stall pointer.
6. Lock (REG_WRITE_ARB_LOCK_EN): req=1111, lock=0010 for 3 transfers → winners 1,1,1. Drop lock[1] → 1, then 2.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared arbiter defaults, requester index type and one-hot decode helper
package mips_pkg;

   localparam int ARB_NUM_REQ_DEFAULT = 4;

   typedef logic [$clog2(ARB_NUM_REQ_DEFAULT)-1:0] arb_id_t;

   // Supports up to 32 requesters; OR-reduction keeps the decode shallow for one-hot inputs.
   function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < 32; i++) begin
         if (oh[i]) idx = idx | i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// rtl/reg_write_arbiter_if.sv - requester-side handshake bundle; lock only with REG_WRITE_ARB_LOCK_EN
interface reg_write_arbiter_if #(
   parameter int WIDTH   = 4,
   parameter int NUM_REQ = 4
);

   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] wdata;
   logic                     stall;
   logic [NUM_REQ-1:0]       gnt;
`ifdef REG_WRITE_ARB_LOCK_EN
   logic [NUM_REQ-1:0]       lock;
`endif

`ifdef REG_WRITE_ARB_LOCK_EN
   modport master (output req, output wdata, output stall, output lock, input gnt);
   modport slave  (input req, input wdata, input stall, input lock, output gnt);
`else
   modport master (output req, output wdata, output stall, input gnt);
   modport slave  (input req, input wdata, input stall, output gnt);
`endif

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick via double-width masked priority encoder
module rr_pick
   import mips_pkg::*;
#(
   parameter int NUM_REQ = ARB_NUM_REQ_DEFAULT,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   input  logic               enable,
   output logic [NUM_REQ-1:0] gnt,
   output logic [PTR_W-1:0]   idx,
   output logic               valid
);

   logic [NUM_REQ-1:0]   hi_mask;
   logic [2*NUM_REQ-1:0] dbl;
   logic [2*NUM_REQ-1:0] dbl_oh;
   logic [NUM_REQ-1:0]   gnt_raw;

   // Lower copy only holds requesters at or above ptr; upper copy catches the wrap.
   always_comb begin
      hi_mask = ~((NUM_REQ'(1) << ptr) - NUM_REQ'(1));
      dbl     = {req, req & hi_mask};
      dbl_oh  = dbl & (~dbl + (2*NUM_REQ)'(1));
      gnt_raw = dbl_oh[NUM_REQ-1:0] | dbl_oh[2*NUM_REQ-1:NUM_REQ];
      valid   = enable && (|req);
      gnt     = valid ? gnt_raw : '0;
      idx     = PTR_W'(onehot_to_idx(32'(gnt_raw)));
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbiter feeding a shared register through registered load/in
// Optional requester lock enabled by defining REG_WRITE_ARB_LOCK_EN.
module reg_write_arbiter
   import mips_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int NUM_REQ = ARB_NUM_REQ_DEFAULT,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic                 clock,
   input  logic                 reset,
   reg_write_arbiter_if.slave   bus,
   output logic                 reg_load,
   output logic [WIDTH-1:0]     reg_in,
   output logic [PTR_W-1:0]     last_id
);

   logic [PTR_W-1:0] ptr_q, ptr_d, ptr_nxt;
   logic             reg_load_q, reg_load_d;
   logic [WIDTH-1:0] reg_in_q, reg_in_d;
   logic [PTR_W-1:0] last_id_q, last_id_d;

   logic [NUM_REQ-1:0] gnt;
   logic [PTR_W-1:0]   win_idx;
   logic               win_valid;

   // Reset is folded into enable so requesters never see a grant while held in reset.
   rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
      .req    (bus.req),
      .ptr    (ptr_q),
      .enable (!bus.stall && reset),
      .gnt    (gnt),
      .idx    (win_idx),
      .valid  (win_valid)
   );

   assign bus.gnt = gnt;

   always_comb begin
      ptr_d      = ptr_q;
      reg_load_d = 1'b0;
      reg_in_d   = reg_in_q;
      last_id_d  = last_id_q;
      ptr_nxt    = (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + PTR_W'(1);
      if (win_valid) begin
         reg_load_d = 1'b1;
         reg_in_d   = bus.wdata[win_idx*WIDTH +: WIDTH];
         last_id_d  = win_idx;
`ifdef REG_WRITE_ARB_LOCK_EN
         ptr_d      = bus.lock[win_idx] ? win_idx : ptr_nxt;
`else
         ptr_d      = ptr_nxt;
`endif
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr_q      <= '0;
         reg_load_q <= 1'b0;
         reg_in_q   <= '0;
         last_id_q  <= '0;
      end else begin
         ptr_q      <= ptr_d;
         reg_load_q <= reg_load_d;
         reg_in_q   <= reg_in_d;
         last_id_q  <= last_id_d;
      end
   end

   assign reg_load = reg_load_q;
   assign reg_in   = reg_in_q;
   assign last_id  = last_id_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed self-checking bench for reg_write_arbiter with a register model
module tb_reg_write_arbiter;
   import mips_pkg::*;

   localparam int WIDTH   = 4;
   localparam int NUM_REQ = ARB_NUM_REQ_DEFAULT;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             reg_load;
   logic [WIDTH-1:0] reg_in;
   arb_id_t          last_id;
   logic [WIDTH-1:0] reg_out = '0;
   int               checks = 0;
   int               failures = 0;

   reg_write_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

   reg_write_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus),
      .reg_load (reg_load),
      .reg_in   (reg_in),
      .last_id  (last_id)
   );

   always #5 clock = ~clock;

   // Shared architectural register: not reset by the arbiter's reset.
   always @(posedge clock) if (reg_load) reg_out <= reg_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   initial begin
      bus.req   = 4'b1111;
      bus.wdata = '0;
      bus.stall = 1'b0;
`ifdef REG_WRITE_ARB_LOCK_EN
      bus.lock  = '0;
`endif
      #3;
      chk("rst_gnt", 32'(bus.gnt), 32'h0);
      chk("rst_load", 32'(reg_load), 32'h0);
      chk("rst_in", 32'(reg_in), 32'h0);
      chk("rst_id", 32'(last_id), 32'h0);
      #3;
      reset   = 1'b1;
      bus.req = 4'b0000;
      #1;
      chk("idle_gnt", 32'(bus.gnt), 32'h0);
      tick();
      chk("idle_load", 32'(reg_load), 32'h0);
      chk("idle_in", 32'(reg_in), 32'h0);

      // single write from requester 2
      bus.req   = 4'b0100;
      bus.wdata = 16'h0A00;
      #1;
      chk("single_gnt", 32'(bus.gnt), 32'h4);
      chk("single_gnt_idx", onehot_to_idx(32'(bus.gnt)), 32'd2);
      tick();
      bus.req = 4'b0000;
      chk("single_load", 32'(reg_load), 32'h1);
      chk("single_in", 32'(reg_in), 32'hA);
      chk("single_id", 32'(last_id), 32'd2);
      tick();
      chk("single_out", 32'(reg_out), 32'hA);
      chk("single_load_drop", 32'(reg_load), 32'h0);

      // pointer is 3: requester 3 absent, wrap to 0 then 1 then 0
      bus.req   = 4'b0011;
      bus.wdata = 16'h0021;
      #1;
      chk("wrap_gnt0", 32'(bus.gnt), 32'h1);
      tick();
      chk("wrap_id0", 32'(last_id), 32'd0);
      chk("wrap_in0", 32'(reg_in), 32'h1);
      chk("wrap_gnt1", 32'(bus.gnt), 32'h2);
      tick();
      chk("wrap_id1", 32'(last_id), 32'd1);
      chk("wrap_load1", 32'(reg_load), 32'h1);
      chk("wrap_out1", 32'(reg_out), 32'h1);
      chk("wrap_gnt2", 32'(bus.gnt), 32'h1);
      tick();
      bus.req = 4'b0000;
      chk("wrap_id2", 32'(last_id), 32'd0);
      chk("wrap_out2", 32'(reg_out), 32'h2);
      tick();
      chk("wrap_out3", 32'(reg_out), 32'h1);

      // reset while a load is pending: nothing reaches the register
      bus.req   = 4'b0010;
      bus.wdata = 16'h0050;
      tick();
      bus.req = 4'b0000;
      chk("pend_load", 32'(reg_load), 32'h1);
      chk("pend_in", 32'(reg_in), 32'h5);
      reset = 1'b0;
      #1;
      chk("async_load", 32'(reg_load), 32'h0);
      chk("async_in", 32'(reg_in), 32'h0);
      chk("async_id", 32'(last_id), 32'd0);
      tick();
      chk("async_out_hold", 32'(reg_out), 32'h1);
      reset = 1'b1;

      // round robin with all requesting, pointer back at 0
      bus.req   = 4'b1111;
      bus.wdata = 16'h4321;
      #1;
      chk("rr_gnt_first", 32'(bus.gnt), 32'h1);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("rr_id", 32'(last_id), 32'(k % 4));
         chk("rr_in", 32'(reg_in), 32'(k % 4 + 1));
         chk("rr_load", 32'(reg_load), 32'h1);
         chk("rr_gnt", 32'(bus.gnt), 32'h1 << ((k + 1) % 4));
         if (k > 0) chk("rr_out", 32'(reg_out), 32'((k - 1) % 4 + 1));
      end

      // stall right after a transfer; pointer is 1
      bus.stall = 1'b1;
      #1;
      chk("stall_gnt", 32'(bus.gnt), 32'h0);
      tick();
      chk("stall_out_kept", 32'(reg_out), 32'h1);
      for (int k = 0; k < 3; k++) begin
         chk("stall_load", 32'(reg_load), 32'h0);
         chk("stall_id", 32'(last_id), 32'd0);
         chk("stall_gnt_hold", 32'(bus.gnt), 32'h0);
         if (k < 2) tick();
      end
      bus.stall = 1'b0;
      #1;
      chk("unstall_gnt", 32'(bus.gnt), 32'h2);
      tick();
      chk("unstall_id", 32'(last_id), 32'd1);
      chk("unstall_in", 32'(reg_in), 32'h2);

      // single requester back-to-back, pointer is 2
      bus.req = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         bus.wdata = 16'(32'(7 + k) << 8);
         #1;
         chk("b2b_gnt", 32'(bus.gnt), 32'h4);
         tick();
         chk("b2b_in", 32'(reg_in), 32'(7 + k));
         chk("b2b_load", 32'(reg_load), 32'h1);
      end
      bus.req = 4'b0000;
      tick();
      chk("b2b_out", 32'(reg_out), 32'h9);

`ifdef REG_WRITE_ARB_LOCK_EN
      // pointer is 3: move it to 1 with a requester-0 transfer, then lock requester 1
      bus.req   = 4'b0001;
      bus.wdata = 16'h4321;
      tick();
      chk("lock_pre_id", 32'(last_id), 32'd0);
      bus.req  = 4'b1111;
      bus.lock = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("lock_gnt", 32'(bus.gnt), 32'h2);
         tick();
         chk("lock_id", 32'(last_id), 32'd1);
      end
      bus.lock = 4'b0000;
      tick();
      chk("unlock_id1", 32'(last_id), 32'd1);
      tick();
      chk("unlock_id2", 32'(last_id), 32'd2);
      bus.req = 4'b0000;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
